uart_tx_drain: RTL and testbench

//   Downstream consumer of the byte FIFO: pops one word at a time from the FIFO read port
//   and serialises it as a UART frame on o_tx (start, DATAW data bits LSB-first,

---
 rtl/uart_tx_drain_pkg.sv | 27 ++
 rtl/uart_baud_cnt.sv | 52 +++++
 rtl/uart_tx_drain.sv | 159 +++++++++++++++
 tb/tb_uart_tx_drain.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_drain_pkg.sv
// Shared definitions for the UART transmit drain block.
//
// Contents:
//   state_e           FSM state encoding, 3 bits, shared by the top level
//   CLKS_PER_BIT_DEF  default number of clock cycles per UART bit
//   DATAW_DEF         default number of data bits per frame
//   cntWidth()        width of a counter that runs 0..n-1, never less than 1 bit
package uart_tx_drain_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   localparam int CLKS_PER_BIT_DEF = 16;
   localparam int DATAW_DEF        = 8;

   // A counter for 0..n-1 needs $clog2(n) bits. A one-value counter still
   // needs a 1-bit register so that the declaration stays legal.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer for the UART transmitter.
//
// The counter runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
// While i_clr is high it is held at 0, so the first bit after a clear is a
// full bit period long.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   i_clr   in   hold the counter at zero
//   o_tick  out  high on the last clock cycle of a bit period
module uart_baud_cnt
   import uart_tx_drain_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   output logic o_tick
);

   localparam int            CW   = cntWidth(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count. The counter wraps to zero on the last cycle of every bit.
   // The FSM changes state only on such a cycle, so the counter is also zero
   // at the start of every new state.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register. Reset puts it at the start of a bit period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick = ~i_clr & (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a show-ahead FIFO.
//
// Whenever the transmitter is idle and the FIFO is not empty, it pops one
// word and sends it on o_tx as a UART frame. The frame is a start bit, DATAW
// data bits LSB first, an optional even-parity bit, and one stop bit.
// Back-to-back frames are separated by exactly one idle cycle. The pop for
// the next word happens in that idle cycle.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset; forces the line high at once
//   i_rd_empty  in   FIFO empty flag
//   i_rd_data   in   FIFO head word, valid whenever i_rd_empty is low
//   o_rd_en     out  FIFO pop strobe, one cycle per word (combinational)
//   o_tx        out  serial line, idle high (registered)
//   o_busy      out  high from the start bit through the stop bit (registered)
module uart_tx_drain
   import uart_tx_drain_pkg::*;
#(
   parameter int DATAW        = DATAW_DEF,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int PARITY_EN    = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_rd_empty,
   input  logic [DATAW-1:0] i_rd_data,
   output logic             o_rd_en,
   output logic             o_tx,
   output logic             o_busy
);

   localparam int            BW       = cntWidth(DATAW);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATAW - 1);

   state_e           state_q,  state_d;
   logic [DATAW-1:0] shReg_q,  shReg_d;
   logic [BW-1:0]    bitCnt_q, bitCnt_d;
   logic             parity_q, parity_d;
   logic             tx_q,     tx_d;
   logic             busy_q,   busy_d;

   logic             baudTick;
   logic             rdEn;

   // The bit timer is held at zero in IDLE. START therefore always lasts a
   // full bit period, counted from the cycle after the pop.
   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) uBaud (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (state_q == ST_IDLE),
      .o_tick (baudTick)
   );

   // The FIFO is sampled only in IDLE. Gating with rst_n keeps the pop strobe
   // low while reset is applied, even if the FIFO already holds data.
   assign rdEn = (state_q == ST_IDLE) & ~i_rd_empty & rst_n;

   // Next-state and next-output logic. o_tx is registered, so each branch
   // computes the line value for the state being entered. The line then
   // changes on the same edge as the state.
   always_comb begin
      state_d  = state_q;
      shReg_d  = shReg_q;
      bitCnt_d = bitCnt_q;
      parity_d = parity_q;
      tx_d     = tx_q;
      busy_d   = busy_q;

      case (state_q)
         ST_IDLE: begin
            tx_d     = 1'b1;
            busy_d   = 1'b0;
            bitCnt_d = '0;
            if (rdEn) begin
               shReg_d  = i_rd_data;
               parity_d = ^i_rd_data;
               state_d  = ST_START;
               tx_d     = 1'b0;
               busy_d   = 1'b1;
            end
         end

         ST_START: begin
            if (baudTick) begin
               state_d  = ST_DATA;
               bitCnt_d = '0;
               tx_d     = shReg_q[0];
            end
         end

         ST_DATA: begin
            if (baudTick) begin
               if (bitCnt_q == LAST_BIT) begin
                  if (PARITY_EN != 0) begin
                     state_d = ST_PARITY;
                     tx_d    = parity_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  shReg_d  = shReg_q >> 1;
                  bitCnt_d = bitCnt_q + BW'(1);
                  tx_d     = shReg_d[0];
               end
            end
         end

         ST_PARITY: begin
            if (baudTick) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end

         ST_STOP: begin
            if (baudTick) begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers. Reset drops any partly sent word and
   // returns the line to mark immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         shReg_q  <= '0;
         bitCnt_q <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shReg_q  <= shReg_d;
         bitCnt_q <= bitCnt_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
      end
   end

   assign o_rd_en = rdEn;
   assign o_tx    = tx_q;
   assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain. Two instances run side by side: instance 0 has no
// parity bit and instance 1 has an even-parity bit. Each instance is fed
// from a queue that behaves like a four-deep show-ahead FIFO.
module tb_uart_tx_drain;

   localparam int DATAW = 8;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       rdEmpty = 2'b11;
   logic [1:0]       rdEn;
   logic [1:0]       tx;
   logic [1:0]       busy;
   logic [DATAW-1:0] rdData [2];
   logic [1:0]       popPend;

   logic [DATAW-1:0] fifoQ [2][$];
   logic [DATAW-1:0] expQ  [2][$];
   int               pushCount [2];
   int               popCount  [2];
   int               checks = 0;
   int               errors = 0;

   always #5 clk = ~clk;

   // One DUT per parity setting, both at four clocks per bit.
   for (genvar g = 0; g < 2; g++) begin : gDut
      uart_tx_drain #(
         .DATAW        (DATAW),
         .CLKS_PER_BIT (CPB),
         .PARITY_EN    (g)
      ) dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_rd_empty (rdEmpty[g]),
         .i_rd_data  (rdData[g]),
         .o_rd_en    (rdEn[g]),
         .o_tx       (tx[g]),
         .o_busy     (busy[g])
      );
   end

   // Compare one value and report it if it differs.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive the FIFO outputs from the queues. When a queue is empty, the data
   // bus carries random values that the DUT must ignore.
   function automatic void refreshFifo();
      for (int g = 0; g < 2; g++) begin
         rdEmpty[g] = (fifoQ[g].size() == 0);
         rdData[g]  = (fifoQ[g].size() == 0) ? DATAW'($urandom) : fifoQ[g][0];
      end
   endfunction

   // Write a word into the FIFO and record it as an expected frame.
   task automatic applyStimulus(input int g, input logic [DATAW-1:0] w);
      fifoQ[g].push_back(w);
      expQ[g].push_back(w);
      pushCount[g]++;
      refreshFifo();
   endtask

   // Advance n clock cycles, then move 1 time unit past the rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait for the pop strobe on instance g, with a cycle limit. On return,
   // the next rising edge is the pop edge.
   task automatic waitPop(input int g);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (rdEn[g]) break;
      end
      checkOutput($sformatf("pop_seen%0d", g), 32'(rdEn[g]), 32'(1));
   endtask

   // Wait until both instances have sent every expected frame, with a cycle
   // limit.
   task automatic waitDrain();
      for (int n = 0; n < 4000; n++) begin
         tick(1);
         if (expQ[0].size() == 0 && expQ[1].size() == 0 &&
             fifoQ[0].size() == 0 && fifoQ[1].size() == 0 && busy == 2'b00) break;
      end
      checkOutput("drain", 32'(expQ[0].size() + expQ[1].size()), 32'(0));
      tick(2);
   endtask

   // FIFO read side. A strobe seen at the falling edge pops the head word just
   // after the rising edge on which the DUT latched it.
   initial begin : fifoProc
      forever begin
         @(negedge clk);
         popPend = rdEn;
         @(posedge clk);
         #1;
         for (int g = 0; g < 2; g++) begin
            if (popPend[g] && fifoQ[g].size() > 0) void'(fifoQ[g].pop_front());
         end
         refreshFifo();
      end
   end

   // Line monitors. They sample at the falling edge, rebuild each frame bit by
   // bit, and compare it with the expected line pattern. The expected pattern
   // is start 0, the data bits LSB first, even parity, then stop 1.
   for (genvar g = 0; g < 2; g++) begin : gMon
      localparam int NBITS = DATAW + 2 + g;
      initial begin : monProc
         logic             inFrame;
         logic             startPending;
         logic             idleAfter;
         logic             prevRdEn;
         int               cyc;
         int               bad;
         logic [NBITS-1:0] lineAct;
         logic [NBITS-1:0] lineExp;
         logic [DATAW-1:0] w;
         inFrame      = 1'b0;
         startPending = 1'b0;
         idleAfter    = 1'b0;
         prevRdEn     = 1'b0;
         cyc          = 0;
         bad          = 0;
         lineAct      = '0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               inFrame      = 1'b0;
               startPending = 1'b0;
               idleAfter    = 1'b0;
               prevRdEn     = 1'b0;
               continue;
            end
            if (startPending) begin
               checkOutput($sformatf("start_latency%0d", g), 32'({tx[g], busy[g]}), 32'(2'b01));
               startPending = 1'b0;
               inFrame      = 1'b1;
               cyc          = 0;
               bad          = 0;
               lineAct      = '0;
            end else if (!inFrame) begin
               checkOutput($sformatf("idle_line%0d", g), 32'({tx[g], busy[g]}), 32'(2'b10));
               if (idleAfter)
                  checkOutput($sformatf("b2b_pop%0d", g), 32'(rdEn[g]), 32'(fifoQ[g].size() > 0));
            end
            idleAfter = 1'b0;
            if (inFrame) begin
               if (cyc % CPB == 0) lineAct[cyc / CPB] = tx[g];
               else if (tx[g] != lineAct[cyc / CPB]) bad++;
               if (!busy[g]) bad++;
               cyc++;
               if (cyc == CPB * NBITS) begin
                  inFrame   = 1'b0;
                  idleAfter = 1'b1;
                  checkOutput($sformatf("frame_expected%0d", g), 32'(expQ[g].size() > 0), 32'(1));
                  if (expQ[g].size() > 0) begin
                     w       = expQ[g].pop_front();
                     lineExp = '0;
                     for (int i = 0; i < DATAW; i++) lineExp[i + 1] = w[i];
                     lineExp[DATAW + 1] = (($countones(w) % 2) == 1);
                     lineExp[NBITS - 1] = 1'b1;
                     checkOutput($sformatf("frame_bits%0d_w%02h", g, w), 32'(lineAct), 32'(lineExp));
                     checkOutput($sformatf("frame_stable%0d", g), 32'(bad), 32'(0));
                  end
               end
            end
            if (rdEn[g]) begin
               popCount[g]++;
               checkOutput($sformatf("pop_cond%0d", g),
                           32'({inFrame, prevRdEn, busy[g], fifoQ[g].size() == 0}), 32'(0));
               startPending = 1'b1;
            end
            prevRdEn = rdEn[g];
         end
      end
   end

   // Stop the run if it never finishes on its own.
   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      refreshFifo();
      rst_n = 1'b0;
      tick(3);
      checkOutput("reset_state", 32'({tx, busy, rdEn}), 32'(6'b11_00_00));
      rst_n = 1'b1;
      tick(20);
      checkOutput("idle_after_reset", 32'({tx, busy, rdEn}), 32'(6'b11_00_00));

      // Single frames: 0xA5 without parity, 0x07 with parity.
      applyStimulus(0, 8'hA5);
      applyStimulus(1, 8'h07);
      waitDrain();

      // Full FIFO drained back to back. 0x03 checks a zero parity bit.
      for (int i = 1; i <= DEPTH; i++) applyStimulus(0, DATAW'(i));
      applyStimulus(1, 8'h03);
      waitDrain();

      // Reset during data bit 3 of 0x3C. The word is dropped, and 0x55 is
      // sent after the release.
      applyStimulus(0, 8'h3C);
      waitPop(0);
      @(posedge clk);
      repeat (17) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_midframe", 32'({tx[0], busy[0], rdEn[0]}), 32'(3'b100));
      checkOutput("inflight_word", 32'(expQ[0].size()), 32'(1));
      if (expQ[0].size() > 0) void'(expQ[0].pop_front());
      tick(3);
      rst_n = 1'b1;
      tick(20);
      checkOutput("no_resend", 32'({tx[0], busy[0]}), 32'(2'b10));
      applyStimulus(0, 8'h55);
      waitDrain();

      // Push 0x80 during the stop bit of 0x11.
      applyStimulus(0, 8'h11);
      waitPop(0);
      @(posedge clk);
      repeat (37) @(posedge clk);
      #1;
      applyStimulus(0, 8'h80);
      waitDrain();

      // Random traffic. Busy and quiet periods alternate, so the FIFO both
      // fills up and runs empty.
      for (int c = 0; c < 3000; c++) begin
         for (int g = 0; g < 2; g++) begin
            if ($urandom_range(0, 99) < (((c / 300) % 2 == 0) ? 15 : 1) && fifoQ[g].size() < DEPTH)
               applyStimulus(g, DATAW'($urandom));
         end
         tick(1);
      end
      waitDrain();

      for (int g = 0; g < 2; g++)
         checkOutput($sformatf("pop_total%0d", g), 32'(popCount[g]), 32'(pushCount[g]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
